barrel_pipe: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational barrel shifter.
- Generalised in width and in mode: rotate left/right, logical shift left, arithmetic shift right.
- One log2 stage per pipeline register, with a valid/ready handshake on input and output and full-pipeline backpressure.
- Sits between the operand register file and the ALU result mux.

---
 rtl/barrel_pkg.sv | 17 +
 rtl/barrel_stage.sv | 31 +++
 rtl/barrel_pipe.sv | 113 +++++++++++
 tb/tb_barrel_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package barrel_pkg;

  // Operation selector carried alongside each beat through the pipeline.
  typedef enum logic [1:0] {
    ROL = 2'b00,
    ROR = 2'b01,
    SLL = 2'b10,
    SRA = 2'b11
  } shift_mode_t;

  // Shift-amount width, which is also the pipeline depth (one stage per shamt bit).
  function automatic int unsigned shamt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One log2 step of the barrel shifter: moves data by SHIFT positions when enabled.
// Purely combinational; the pipeline registers live in barrel_pipe.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] data_out
);

  // Select the shifted/rotated form for this stage, or pass through.
  always_comb begin
    data_out = data_in;
    if (enable) begin
      unique case (mode)
        ROL: data_out = {data_in[WIDTH-SHIFT-1:0], data_in[WIDTH-1:WIDTH-SHIFT]};
        ROR: data_out = {data_in[SHIFT-1:0], data_in[WIDTH-1:SHIFT]};
        SLL: data_out = {data_in[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        // Sign bit is preserved by every earlier SRA stage, so the current MSB
        // is still the original operand's sign.
        SRA: data_out = {{SHIFT{data_in[WIDTH-1]}}, data_in[WIDTH-1:SHIFT]};
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/barrel_pipe.sv
// Pipelined barrel shifter: rotate left/right, logical shift left, arithmetic
// shift right. One pipeline register per shamt bit (LSB first), valid/ready
// handshake on both sides with whole-pipeline stall under backpressure.
// Optional feature macro: BARREL_ZERO_FLAG_EN adds a registered out_zero flag.
module barrel_pipe
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = shamt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_mode_t        in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef BARREL_ZERO_FLAG_EN
  ,
  output logic               out_zero
`endif
);

  // Pipeline state, index k is the register after stage k.
  logic [SHAMT_W-1:0] valid_q;
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  shift_mode_t        mode_q  [SHAMT_W];

  // Inputs and outputs of each combinational stage.
  logic [SHAMT_W-1:0] stage_valid;
  logic [WIDTH-1:0]   stage_data  [SHAMT_W];
  logic [SHAMT_W-1:0] stage_shamt [SHAMT_W];
  shift_mode_t        stage_mode  [SHAMT_W];
  logic [WIDTH-1:0]   stage_out   [SHAMT_W];

  logic advance;
  logic accept;

  // The whole pipeline moves together; it only stalls when the output is held.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_valid[k] = accept;
      assign stage_data[k]  = in_data;
      assign stage_shamt[k] = in_shamt;
      assign stage_mode[k]  = in_mode;
    end else begin : g_rest
      assign stage_valid[k] = valid_q[k-1];
      assign stage_data[k]  = data_q[k-1];
      assign stage_shamt[k] = shamt_q[k-1];
      assign stage_mode[k]  = mode_q[k-1];
    end

    barrel_stage #(
      .WIDTH (WIDTH),
      .SHIFT (2 ** k)
    ) u_stage (
      .data_in  (stage_data[k]),
      .enable   (stage_shamt[k][k]),
      .mode     (stage_mode[k]),
      .data_out (stage_out[k])
    );
  end

  // Pipeline registers: clear everything on reset, shift forward on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= ROL;
      end
    end else if (advance) begin
      valid_q <= stage_valid;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= stage_out[k];
        shamt_q[k] <= stage_shamt[k];
        mode_q[k]  <= stage_mode[k];
      end
    end
  end

  assign out_valid = valid_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];

`ifdef BARREL_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag registered in lockstep with the last data stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (advance) begin
      zero_q <= (stage_out[SHAMT_W-1] == '0);
    end
  end

  assign out_zero = zero_q;
`endif

  // The last stage's control fields have no consumer beyond the pipeline end.
  logic unused_last;
  assign unused_last = ^{shamt_q[SHAMT_W-1], mode_q[SHAMT_W-1]};

endmodule

// File: tb/tb_barrel_pipe.sv
// Scoreboard bench for barrel_pipe (WIDTH=16, latency 4).
module tb_barrel_pipe;
  import barrel_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  shift_mode_t   in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef BARREL_ZERO_FLAG_EN
  logic          out_zero;
`endif

  barrel_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARREL_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } sb_t;

  sb_t          sb[$];
  int           n_total = 0;
  int           n_bad   = 0;
  int           cyc     = 0;
  int           out_cnt = 0;
  logic         lat_chk = 1'b1;
  logic [W-1:0] cur_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: bitwise definition of each operation.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input shift_mode_t m);
    logic [W-1:0] r;
    r = '0;
    case (m)
      ROL: for (int i = 0; i < W; i++) r[(i + s) % W] = d[i];
      ROR: for (int i = 0; i < W; i++) r[i] = d[(i + s) % W];
      SLL: r = d << s;
      SRA: r = W'($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample between edges, pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          check("stray_out", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("data", 32'(out_data), 32'(e.data));
`ifdef BARREL_ZERO_FLAG_EN
          check("zero", 32'(out_zero), 32'(e.data == '0));
`endif
          if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end
      if (in_valid && in_ready) sb.push_back('{data: cur_exp, cyc: cyc});
    end
  end

  task automatic send(input logic [W-1:0] d, input int s, input shift_mode_t m,
                      input logic [W-1:0] exp);
    int n;
    cur_exp  = exp;
    in_data  = d;
    in_shamt = SW'(s);
    in_mode  = m;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  int           idx;
  int           cnt0;
  logic         acc;
  logic [W-1:0] held;
  logic [W-1:0] d;
  shift_mode_t  m;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = ROL;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BARREL_ZERO_FLAG_EN
    check("rst_out_zero", 32'(out_zero), 32'd0);
`endif
    rst = 1'b0;

    // Directed cases with hand-derived results.
    send(16'hAAAA, 1, ROL, 16'h5555);
    wait_drain("drain_first");
    send(16'hAAAA, 0, ROL, 16'hAAAA);
    send(16'h8001, 4, ROL, 16'h0018);
    send(16'h8111, 8, ROL, 16'h1181);
    send(16'h0001, 1, ROR, 16'h8000);
    send(16'hFFFF, 15, SLL, 16'h8000);
    send(16'h8000, 15, SRA, 16'hFFFF);
    send(16'h7000, 4, SRA, 16'h0700);
    send(16'h1234, 0, ROR, 16'h1234);
    send(16'h8765, 0, SRA, 16'h8765);
    send(16'h0001, 0, SLL, 16'h0001);
    send(16'h8000, 1, SLL, 16'h0000);
    wait_drain("drain_directed");

    // Random beats against the reference model.
    for (int i = 0; i < 24; i++) begin
      d = W'($urandom);
      m = shift_mode_t'($urandom_range(3, 0));
      idx = int'($urandom_range(SW'(W - 1), 0));
      send(d, idx, m, model(d, idx, m));
    end
    wait_drain("drain_random");

    // Back-to-back stream: one accept per cycle, so fixed latency means no gaps.
    for (int n = 0; n < 16; n++) send(16'h0001, n, ROL, 16'(16'h0001 << n));
    wait_drain("drain_stream");

    // Backpressure: fill with out_ready low, hold 5 cycles, then release.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    cnt0      = out_cnt;
    idx       = 0;
    in_valid  = 1'b1;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      d        = 16'h0F0F ^ W'(idx * 16'h1357);
      m        = shift_mode_t'(idx[1:0]);
      in_data  = d;
      in_shamt = SW'(idx + 3);
      in_mode  = m;
      cur_exp  = model(d, (idx + 3) % W, m);
      acc      = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("bp_full", 32'(out_valid), 32'd1);
    check("bp_accepted", 32'(idx), 32'(LAT));
    held = out_data;
    repeat (5) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold", 32'(out_data), 32'(held));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_bp");
    check("bp_count", 32'(out_cnt - cnt0), 32'(LAT));
    lat_chk = 1'b1;

    // Reset with three beats in flight: nothing may emerge afterwards.
    send(16'h1111, 1, ROL, 16'h2222);
    send(16'h2222, 2, ROL, 16'h8888);
    send(16'h3333, 3, SLL, 16'h9998);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    cur_exp  = 16'hBEEF;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    cnt0     = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("rst_flush", 32'(out_cnt - cnt0), 32'd0);

    // Pipeline still works after the flush.
    send(16'h00F0, 4, ROR, 16'h000F);
    wait_drain("drain_final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
